cond_exec_unit: RTL and testbench

COND_EXEC_UNIT -- requirements
Module: cond_exec_unit

---
 rtl/cond_exec_unit_pkg.sv | 35 +++
 rtl/cond_exec_unit_cond_eval.sv | 44 ++++
 rtl/cond_exec_unit.sv | 166 ++++++++++++++++
 tb/tb_cond_exec_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cond_exec_unit_pkg.sv
// Shared constants and types for the conditional-execution unit.
// Holds condition codes, flag bit positions, widths and FSM encoding.
package cond_exec_unit_pkg;

  localparam int STAT_W = 4;
  localparam int COND_W = 4;

  localparam int FLAG_Z = 3;
  localparam int FLAG_C = 2;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 0;

  localparam logic [COND_W-1:0] CC_EQ = 4'b0000;
  localparam logic [COND_W-1:0] CC_NE = 4'b0001;
  localparam logic [COND_W-1:0] CC_CS = 4'b0010;
  localparam logic [COND_W-1:0] CC_CC = 4'b0011;
  localparam logic [COND_W-1:0] CC_MI = 4'b0100;
  localparam logic [COND_W-1:0] CC_PL = 4'b0101;
  localparam logic [COND_W-1:0] CC_VS = 4'b0110;
  localparam logic [COND_W-1:0] CC_VC = 4'b0111;
  localparam logic [COND_W-1:0] CC_HI = 4'b1000;
  localparam logic [COND_W-1:0] CC_LS = 4'b1001;
  localparam logic [COND_W-1:0] CC_GE = 4'b1010;
  localparam logic [COND_W-1:0] CC_LT = 4'b1011;
  localparam logic [COND_W-1:0] CC_GT = 4'b1100;
  localparam logic [COND_W-1:0] CC_LE = 4'b1101;
  localparam logic [COND_W-1:0] CC_AL = 4'b1110;
  localparam logic [COND_W-1:0] CC_NV = 4'b1111;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } it_state_e;

endpackage

// File: rtl/cond_exec_unit_cond_eval.sv
// Single-channel condition evaluator.
// Maps a 4-bit condition code and {Z,C,N,V} flags to pass/fail.
module cond_eval
  import cond_exec_unit_pkg::*;
(
  input  logic [COND_W-1:0] cond,
  input  logic [STAT_W-1:0] flags,
  output logic              result
);

  logic z;
  logic c;
  logic n;
  logic v;

  assign z = flags[FLAG_Z];
  assign c = flags[FLAG_C];
  assign n = flags[FLAG_N];
  assign v = flags[FLAG_V];

  // Decode the condition code against the flags
  always_comb begin
    result = 1'b0;
    unique case (cond)
      CC_EQ: result = z;
      CC_NE: result = !z;
      CC_CS: result = c;
      CC_CC: result = !c;
      CC_MI: result = n;
      CC_PL: result = !n;
      CC_VS: result = v;
      CC_VC: result = !v;
      CC_HI: result = c && !z;
      CC_LS: result = !c || z;
      CC_GE: result = (n == v);
      CC_LT: result = (n != v);
      CC_GT: result = !z && (n == v);
      CC_LE: result = z || (n != v);
      CC_AL: result = 1'b1;
      CC_NV: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_exec_unit.sv
// Conditional-execution unit: status register, per-channel evaluation
// and a predicated-block sequencer that overrides channel 0.
module cond_exec_unit
  import cond_exec_unit_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int MAX_IT = 4,
  parameter int BYPASS = 1,
  localparam int LEN_W = $clog2(MAX_IT + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stat_wr_en,
  input  logic [STAT_W-1:0]          stat_in,
  output logic [STAT_W-1:0]          stat_reg,
  input  logic [COND_W*NUM_CH-1:0]   cond_in,
  output logic [NUM_CH-1:0]          cond_state,
  input  logic                       inst_adv,
  input  logic                       it_start,
  input  logic [COND_W-1:0]          it_cond,
  input  logic [LEN_W-1:0]           it_len,
  input  logic [MAX_IT-1:0]          it_else,
  input  logic                       flush,
  output logic                       it_active,
  output logic                       it_err
);

  it_state_e         state_q, state_d;
  logic [LEN_W-1:0]  idx_q, idx_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic [COND_W-1:0] cond_q, cond_d;
  logic [MAX_IT-1:0] else_q, else_d;
  logic [STAT_W-1:0] stat_q, stat_d;
  logic              err_q, err_d;
  logic              active_q, active_d;

  logic [STAT_W-1:0] eval_flags;
  logic [COND_W-1:0] eff_cond [NUM_CH];
  logic              else_bit;
  logic              len_ok;
  logic              last_slot;

  assign stat_reg  = stat_q;
  assign it_active = active_q;
  assign it_err    = err_q;

  assign len_ok = (it_len != '0) &&
                  (it_len <= LEN_W'(MAX_IT));
  assign last_slot = (idx_q == len_q - LEN_W'(1));

  // A status write in the same cycle may be forwarded to evaluation
  always_comb begin
    eval_flags = stat_q;
    if ((BYPASS != 0) && stat_wr_en) begin
      eval_flags = stat_in;
    end
  end

  // Select the else bit of the current slot
  always_comb begin
    else_bit = 1'b0;
    for (int i = 0; i < MAX_IT; i++) begin
      if (idx_q == LEN_W'(i)) begin
        else_bit = else_q[i];
      end
    end
  end

  // Channel 0 follows the block condition while a block is active
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      eff_cond[k] = cond_in[COND_W*k +: COND_W];
    end
    if (state_q == ST_ACTIVE) begin
      eff_cond[0] = {cond_q[COND_W-1:1],
                     cond_q[0] ^ else_bit};
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    cond_eval u_eval (
      .cond   (eff_cond[k]),
      .flags  (eval_flags),
      .result (cond_state[k])
    );
  end

  // Status register next value; flush does not touch it
  always_comb begin
    stat_d = stat_q;
    if (stat_wr_en) begin
      stat_d = stat_in;
    end
  end

  // Block sequencer next state; flush wins over start and advance
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    cond_d  = cond_q;
    else_d  = else_q;
    err_d   = 1'b0;
    if (flush) begin
      state_d = ST_IDLE;
      idx_d   = '0;
    end else begin
      unique case (1'b1)
        (state_q == ST_IDLE): begin
          if (it_start) begin
            if (len_ok) begin
              state_d = ST_ACTIVE;
              idx_d   = '0;
              len_d   = it_len;
              cond_d  = it_cond;
              else_d  = it_else;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        (state_q == ST_ACTIVE): begin
          if (it_start) begin
            err_d = 1'b1;
          end
          if (inst_adv) begin
            if (last_slot) begin
              state_d = ST_IDLE;
              idx_d   = '0;
            end else begin
              idx_d = idx_q + LEN_W'(1);
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    active_d = (state_d == ST_ACTIVE);
  end

  // All state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      len_q    <= '0;
      cond_q   <= '0;
      else_q   <= '0;
      stat_q   <= '0;
      err_q    <= 1'b0;
      active_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      len_q    <= len_d;
      cond_q   <= cond_d;
      else_q   <= else_d;
      stat_q   <= stat_d;
      err_q    <= err_d;
      active_q <= active_d;
    end
  end

endmodule

// File: tb/tb_cond_exec_unit.sv
// Scoreboard bench for cond_exec_unit: stimulus queues expectations,
// a monitor process pops and compares them at each sample event.
module tb_cond_exec_unit;

  logic       clk;
  logic       rst;
  logic       stat_wr_en;
  logic [3:0] stat_in;
  logic [3:0] stat_reg;
  logic [7:0] cond_in;
  logic [1:0] cond_state;
  logic       inst_adv;
  logic       it_start;
  logic [3:0] it_cond;
  logic [2:0] it_len;
  logic [3:0] it_else;
  logic       flush;
  logic       it_active;
  logic       it_err;

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    int         sel;
    logic [7:0] exp;
  } exp_t;

  exp_t q[$];
  event sample_ev;

  cond_exec_unit #(
    .NUM_CH (2),
    .MAX_IT (4),
    .BYPASS (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stat_wr_en (stat_wr_en),
    .stat_in    (stat_in),
    .stat_reg   (stat_reg),
    .cond_in    (cond_in),
    .cond_state (cond_state),
    .inst_adv   (inst_adv),
    .it_start   (it_start),
    .it_cond    (it_cond),
    .it_len     (it_len),
    .it_else    (it_else),
    .flush      (flush),
    .it_active  (it_active),
    .it_err     (it_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic ref_cc(input logic [3:0] cc,
                                  input logic [3:0] f);
    logic z, c, n, v, b;
    z = f[3];
    c = f[2];
    n = f[1];
    v = f[0];
    case (cc[3:1])
      3'd0:    b = z;
      3'd1:    b = c;
      3'd2:    b = n;
      3'd3:    b = v;
      3'd4:    b = c & ~z;
      3'd5:    b = (n == v);
      3'd6:    b = ~z & (n == v);
      default: b = 1'b1;
    endcase
    return b ^ cc[0];
  endfunction

  task automatic chk(input string n, input int s,
                     input logic [7:0] e);
    exp_t t;
    t.name = n;
    t.sel  = s;
    t.exp  = e;
    q.push_back(t);
  endtask

  task automatic fire();
    #1;
    ->sample_ev;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pop every queued expectation and compare with the DUT
  initial begin
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(sample_ev);
      while (q.size() != 0) begin
        e = q.pop_front();
        case (e.sel)
          0:       act = {6'b0, cond_state};
          1:       act = {4'b0, stat_reg};
          2:       act = {7'b0, it_active};
          default: act = {7'b0, it_err};
        endcase
        checks++;
        if (act !== e.exp) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h",
                   e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    logic [3:0] f;
    logic [3:0] cc;
    rst        = 1'b1;
    stat_wr_en = 1'b0;
    stat_in    = 4'h0;
    cond_in    = 8'hFE;
    inst_adv   = 1'b0;
    it_start   = 1'b0;
    it_cond    = 4'h0;
    it_len     = 3'd0;
    it_else    = 4'h0;
    flush      = 1'b0;
    chk("rst_stat", 1, 8'h0);
    chk("rst_act", 2, 8'h0);
    chk("rst_err", 3, 8'h0);
    chk("rst_cs", 0, 8'h1);
    fire();
    tick();
    tick();
    rst = 1'b0;

    // same-cycle bypass, then registered status
    stat_wr_en = 1'b1;
    stat_in    = 4'h8;
    cond_in    = 8'h10;
    chk("bypass_cs", 0, 8'h1);
    fire();
    tick();
    stat_wr_en = 1'b0;
    chk("stat_upd", 1, 8'h8);
    chk("hold_cs", 0, 8'h1);
    fire();

    // signed compares with N=1 V=0 Z=0
    stat_wr_en = 1'b1;
    stat_in    = 4'h2;
    tick();
    stat_wr_en = 1'b0;
    cond_in = 8'hCD;
    chk("le_gt", 0, 8'h1);
    fire();
    cond_in = 8'hEF;
    chk("nv_al", 0, 8'h2);
    fire();

    // three-slot block with else on slot 1, Z=1
    stat_wr_en = 1'b1;
    stat_in    = 4'h8;
    tick();
    stat_wr_en = 1'b0;
    cond_in  = 8'h0F;
    it_start = 1'b1;
    it_cond  = 4'h0;
    it_len   = 3'd3;
    it_else  = 4'b0010;
    tick();
    it_start = 1'b0;
    chk("blk_act", 2, 8'h1);
    chk("slot0", 0, 8'h3);
    fire();
    inst_adv = 1'b1;
    tick();
    chk("slot1", 0, 8'h2);
    chk("slot1_act", 2, 8'h1);
    fire();
    tick();
    chk("slot2", 0, 8'h3);
    chk("slot2_act", 2, 8'h1);
    fire();
    tick();
    inst_adv = 1'b0;
    chk("blk_end", 2, 8'h0);
    chk("blk_end_cs", 0, 8'h2);
    fire();

    // flush at idx=1
    it_start = 1'b1;
    it_len   = 3'd4;
    it_else  = 4'h0;
    tick();
    it_start = 1'b0;
    inst_adv = 1'b1;
    tick();
    inst_adv = 1'b0;
    chk("pre_flush", 2, 8'h1);
    fire();
    flush = 1'b1;
    tick();
    flush   = 1'b0;
    cond_in = 8'h01;
    chk("flush_act", 2, 8'h0);
    chk("flush_cs", 0, 8'h2);
    chk("flush_stat", 1, 8'h8);
    fire();

    // flush overrides a start
    it_start = 1'b1;
    it_len   = 3'd2;
    flush    = 1'b1;
    tick();
    it_start = 1'b0;
    flush    = 1'b0;
    chk("flush_st_act", 2, 8'h0);
    chk("flush_st_err", 3, 8'h0);
    fire();

    // illegal lengths and start while busy
    it_start = 1'b1;
    it_len   = 3'd0;
    tick();
    it_start = 1'b0;
    chk("len0_err", 3, 8'h1);
    chk("len0_act", 2, 8'h0);
    fire();
    tick();
    chk("err_pulse", 3, 8'h0);
    fire();
    it_start = 1'b1;
    it_len   = 3'd5;
    tick();
    it_start = 1'b0;
    chk("len5_err", 3, 8'h1);
    chk("len5_act", 2, 8'h0);
    fire();
    it_start = 1'b1;
    it_len   = 3'd2;
    it_cond  = 4'h1;
    tick();
    chk("start_ok_act", 2, 8'h1);
    chk("start_ok_err", 3, 8'h0);
    fire();
    tick();
    it_start = 1'b0;
    cond_in  = 8'h00;
    chk("busy_err", 3, 8'h1);
    chk("busy_act", 2, 8'h1);
    chk("busy_slot0", 0, 8'h2);
    fire();
    tick();
    chk("busy_err_clr", 3, 8'h0);
    fire();
    inst_adv = 1'b1;
    tick();
    tick();
    inst_adv = 1'b0;
    chk("blk2_end", 2, 8'h0);
    fire();

    // start with advance in the same cycle
    cond_in  = 8'h01;
    it_start = 1'b1;
    it_cond  = 4'h0;
    it_len   = 3'd1;
    it_else  = 4'h0;
    inst_adv = 1'b1;
    chk("adv_unpred", 0, 8'h2);
    fire();
    tick();
    it_start = 1'b0;
    inst_adv = 1'b0;
    chk("adv_act", 2, 8'h1);
    chk("adv_slot0", 0, 8'h3);
    fire();
    inst_adv = 1'b1;
    tick();
    inst_adv = 1'b0;
    chk("len1_end", 2, 8'h0);
    fire();

    // asynchronous reset at idx=2
    it_start = 1'b1;
    it_len   = 3'd4;
    tick();
    it_start = 1'b0;
    inst_adv = 1'b1;
    tick();
    tick();
    inst_adv = 1'b0;
    chk("mid_act", 2, 8'h1);
    chk("mid_stat", 1, 8'h8);
    fire();
    rst = 1'b1;
    chk("async_act", 2, 8'h0);
    chk("async_stat", 1, 8'h0);
    fire();
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_act", 2, 8'h0);
    fire();

    // full decode sweep through the bypass path
    for (int fi = 0; fi < 16; fi++) begin
      for (int ci = 0; ci < 16; ci++) begin
        tick();
        f          = 4'(fi);
        cc         = 4'(ci);
        stat_wr_en = 1'b1;
        stat_in    = f;
        cond_in    = {~cc, cc};
        chk($sformatf("sweep_f%h_c%h", f, cc), 0,
            {6'b0, ref_cc(~cc, f), ref_cc(cc, f)});
        fire();
      end
    end
    stat_wr_en = 1'b0;

    #5;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0",
               q.size());
    end
    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
